mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Round-robin arbiter muxing NUM_PORTS requesters (I-fetch, LSU, AMO unit, debug) onto one mem port.
//   Generalises the single core<->mem link to N channels on the existing re/we/mask/read_resp handshake.
//   Adds lock support so an AMO read-modify-write pair cannot be split by another port.
//   Sits between core and mem inside the core top level.
// PARAMETERS
//   DATA_WIDTH  32  data bus width (bits)
//   ADDR_WIDTH  32  address width (bits)
//   NUM_PORTS   2   requester count, >=2
//   MASK_WIDTH  DATA_WIDTH/8  byte-mask width
// PORTS
//   clk            in   1                     clock, rising edge
//   arst_n         in   1                     reset, synchronous, active-low
//   req_valid      in   NUM_PORTS             per-port request valid
//   req_we         in   NUM_PORTS             1=write, 0=read
//   req_lock       in   NUM_PORTS             keep grant after this request
//   req_addr       in   NUM_PORTS*ADDR_WIDTH  flattened; port i at [i*AW +: AW]
//   req_wdata      in   NUM_PORTS*DATA_WIDTH  flattened write data
//   req_mask       in   NUM_PORTS*MASK_WIDTH  flattened byte mask
//   req_ready      out  NUM_PORTS             one-hot: request accepted this cycle
//   resp_valid     out  NUM_PORTS             one-hot: response for port i
//   resp_rdata     out  DATA_WIDTH            read data, valid with resp_valid on a read
//   mem_re         out  1                     read enable to mem
//   mem_we         out  1                     write enable to mem
//   mem_addr       out  ADDR_WIDTH            address to mem
//   mem_data_in    out  DATA_WIDTH            write data to mem
//   mem_mask       out  MASK_WIDTH            byte mask to mem
//   mem_data_out   in   DATA_WIDTH            read data from mem
//   mem_read_resp  in   1                     read data valid from mem
// BEHAVIOUR
//   Reset (arst_n=0 at posedge): state=IDLE, rr_ptr=0, owner=0, lock_q=0; req_ready, resp_valid,
//     mem_re, mem_we = 0; resp_rdata, mem_addr, mem_data_in, mem_mask = 0. Reset mid-read drops it silently.
//   FSM states: IDLE, READ_WAIT, WRITE_ACK.
//   IDLE, lock_q=0: grant = first valid port scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
//   IDLE, lock_q=1: only owner eligible; other ports stall even if valid.
//   Issue (combinational in grant cycle): req_ready[g]=1; mem_re=~req_we[g], mem_we=req_we[g];
//     mem_addr/data_in/mask = port g fields. All mem_* zero when no issue.
//   On issue: owner<=g; rr_ptr<=(g+1) mod NUM_PORTS; lock_q<=req_lock[g];
//     state<=READ_WAIT on read, WRITE_ACK on write.
//   READ_WAIT: no issue; on mem_read_resp: resp_valid[owner]=1, resp_rdata=mem_data_out
//     (same cycle, combinational), state<=IDLE. Waits indefinitely; no timeout.
//   WRITE_ACK: resp_valid[owner]=1 for exactly 1 cycle, state<=IDLE.
//   Latency: write resp = issue+1; read resp = mem_read_resp cycle. At most 1 outstanding transaction;
//     next issue no earlier than the cycle after the response.
//   Lock: lock_q set by a request with req_lock=1; cleared by the owner's next request with req_lock=0
//     (that request still issues). Lock also blocks rr_ptr from giving other ports a turn.
//   mem_read_resp outside READ_WAIT is ignored (no resp_valid).
//   Requester must hold req_* stable while req_valid=1 and req_ready=0.
//   NUM_PORTS not power of 2: rr_ptr wraps from NUM_PORTS-1 to 0 explicitly.
// TESTING
//   1. Reset: arst_n=0 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, mem_re=mem_we=0.
//   2. Port0 read 0x100, mem_read_resp 3 cycles later with 0xDEADBEEF -> resp_valid=2'b01, rdata=0xDEADBEEF.
//   3. Ports 0,1 both request continuously, writes -> grants alternate 0,1,0,1; each resp 1 cycle after issue.
//   4. NUM_PORTS=3, port1 read lock=1 then write lock=0 while port0,2 valid -> port1 gets both back-to-back,
//      then port2 granted next.
//   5. Spurious mem_read_resp in IDLE -> no resp_valid; reset during READ_WAIT -> IDLE, resp never fires.
//   6. Port0 write mask 4'b0010 addr 0x8 data 0xAABBCCDD -> mem_we=1, mem_mask=4'b0010, same-cycle req_ready[0].

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter that multiplexes NUM_PORTS requesters
//            (I-fetch, LSU, AMO unit, debug) onto a single memory port using
//            the re/we/mask/read_resp handshake. A lock bit lets one requester
//            hold the port across a read-modify-write pair.
// Ports    : clk, arst_n (synchronous, active-low)
//            req_valid/req_we/req_lock [NUM_PORTS]      per-port request
//            req_addr/req_wdata/req_mask (flattened)    port i at [i*W +: W]
//            req_ready  [NUM_PORTS]  one-hot accept, same cycle as issue
//            resp_valid [NUM_PORTS]  one-hot response, resp_rdata on reads
//            mem_re/mem_we/mem_addr/mem_data_in/mem_mask   memory request
//            mem_data_out/mem_read_resp                    memory read return
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS-1:0]             req_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_mask,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             mem_re,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    output logic [MASK_WIDTH-1:0]            mem_mask,
    input  logic [DATA_WIDTH-1:0]            mem_data_out,
    input  logic                             mem_read_resp
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [PTR_W-1:0] c_last_port   = PTR_W'(NUM_PORTS - 1);

    localparam logic [1:0]       c_st_idle      = 2'd0;
    localparam logic [1:0]       c_st_read_wait = 2'd1;
    localparam logic [1:0]       c_st_write_ack = 2'd2;

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_owner;
    logic             r_lock;

    logic             w_gnt_vld;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_scan;
    logic             w_rd_done;
    logic             w_wr_done;

    // Explicit wrap so non-power-of-two port counts never index past the end.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        wrap_inc = (p == c_last_port) ? '0 : p + 1'b1;
    endfunction

    // Grant selection. Outputs are forced quiet while reset is held so a
    // requester cannot be acknowledged by a transaction that will be dropped.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = r_rr_ptr;
        if (arst_n && (r_state == c_st_idle)) begin
            if (r_lock) begin
                // Locked: only the owner may issue, everyone else stalls.
                w_gnt_vld = req_valid[r_owner];
                w_gnt_idx = r_owner;
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (!w_gnt_vld && req_valid[w_scan]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = w_scan;
                    end
                    w_scan = wrap_inc(w_scan);
                end
            end
        end
    end

    assign w_rd_done = arst_n && (r_state == c_st_read_wait) && mem_read_resp;
    assign w_wr_done = arst_n && (r_state == c_st_write_ack);

    // Issue and response paths are combinational so the accept lands in the
    // grant cycle and read data is forwarded in the mem_read_resp cycle.
    always_comb begin
        req_ready   = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_mask    = '0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_idx] = 1'b1;
            mem_re      = ~req_we[w_gnt_idx];
            mem_we      = req_we[w_gnt_idx];
            mem_addr    = req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_in = req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_mask    = req_mask[w_gnt_idx*MASK_WIDTH +: MASK_WIDTH];
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        if (w_rd_done || w_wr_done) begin
            resp_valid[r_owner] = 1'b1;
        end
        if (w_rd_done) begin
            resp_rdata = mem_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_lock   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_gnt_vld) begin
                        r_owner  <= w_gnt_idx;
                        r_rr_ptr <= wrap_inc(w_gnt_idx);
                        // The owner's next unlocked request releases the lock.
                        r_lock   <= req_lock[w_gnt_idx];
                        r_state  <= req_we[w_gnt_idx] ? c_st_write_ack : c_st_read_wait;
                    end
                end
                c_st_read_wait: begin
                    if (mem_read_resp) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_write_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
